multicycle_controller: RTL and testbench

- Moore-style main control FSM for the multi-cycle MIPS datapath; sits directly upstream of the ALU.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the ALU's ALUConf/Sign inputs plus every datapath mux select and write enable.
- Consumes the ALU Zero flag for branch resolution.

---
 rtl/multicycle_controller_pkg.sv | 74 +++++++
 rtl/multicycle_controller_if.sv | 34 +++
 rtl/multicycle_controller_alu_function_decode.sv | 47 ++++
 rtl/multicycle_controller.sv | 152 +++++++++++++++
 tb/tb_multicycle_controller.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared encodings for the multi-cycle MIPS control FSM.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_LWWB  = 4'd4,
        S_MWR   = 4'd5,
        S_REX   = 4'd6,
        S_RWB   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9,
        S_IEX   = 4'd10,
        S_IWB   = 4'd11,
        S_JR    = 4'd12
    } state_t;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SL   = 5'd6,
        ALU_SR   = 5'd7,
        ALU_COMP = 5'd8
    } alu_conf_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0a,
        OP_SLTIU = 6'h0b,
        OP_ANDI  = 6'h0c,
        OP_LUI   = 6'h0f,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL  = 6'h00,
        F_SRL  = 6'h02,
        F_SRA  = 6'h03,
        F_JR   = 6'h08,
        F_ADD  = 6'h20,
        F_ADDU = 6'h21,
        F_SUB  = 6'h22,
        F_SUBU = 6'h23,
        F_AND  = 6'h24,
        F_OR   = 6'h25,
        F_XOR  = 6'h26,
        F_NOR  = 6'h27,
        F_SLT  = 6'h2a,
        F_SLTU = 6'h2b
    } funct_t;

    typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} reg_dst_t;
    typedef enum logic [1:0] {WB_ALUOUT, WB_MDR, WB_PC} mem_to_reg_t;
    typedef enum logic [1:0] {SRCA_PC, SRCA_RS, SRCA_SHAMT} src_a_t;
    typedef enum logic [1:0] {SRCB_RT, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SL2} src_b_t;
    typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP, PC_RS} pc_src_t;

    function automatic logic is_imm_alu(logic [5:0] op);
        return op inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI};
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields and flag into the controller, datapath controls out.
interface multicycle_controller_if #(parameter int STATE_W = 4);
    logic [5:0]         OpCode;
    logic [5:0]         Funct;
    logic               Zero;
    logic               PCWrite;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic [1:0]         RegDst;
    logic [1:0]         MemtoReg;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic               ExtOp;
    logic               LuiOp;
    logic [1:0]         PCSource;
    logic [4:0]         ALUConf;
    logic               Sign;
    logic [STATE_W-1:0] State;

    modport master (
        input  OpCode, Funct, Zero,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ExtOp, LuiOp, PCSource, ALUConf, Sign, State
    );

    modport slave (
        output OpCode, Funct, Zero,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ExtOp, LuiOp, PCSource, ALUConf, Sign, State
    );
endinterface

// File: rtl/multicycle_controller_alu_function_decode.sv
// multicycle_controller_alu_function_decode: ALU operation from funct (R-type execute) or opcode (I-type execute).
module multicycle_controller_alu_function_decode
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       in_rex,
    output alu_conf_t  alu_conf,
    output logic       sign,
    output logic       is_shift,
    output logic       funct_valid
);
    always_comb begin
        alu_conf = ALU_ADD;
        sign     = 1'b0;
        if (in_rex) begin
            case (funct)
                F_ADD:  sign = 1'b1;
                F_SUB:  begin alu_conf = ALU_SUB; sign = 1'b1; end
                F_SUBU: alu_conf = ALU_SUB;
                F_AND:  alu_conf = ALU_AND;
                F_OR:   alu_conf = ALU_OR;
                F_XOR:  alu_conf = ALU_XOR;
                F_NOR:  alu_conf = ALU_NOR;
                F_SLT:  begin alu_conf = ALU_COMP; sign = 1'b1; end
                F_SLTU: alu_conf = ALU_COMP;
                F_SLL:  alu_conf = ALU_SL;
                F_SRL:  alu_conf = ALU_SR;
                F_SRA:  begin alu_conf = ALU_SR; sign = 1'b1; end
                default: ;
            endcase
        end else begin
            case (op_code)
                OP_ADDI:  sign = 1'b1;
                OP_ANDI:  alu_conf = ALU_AND;
                OP_SLTI:  begin alu_conf = ALU_COMP; sign = 1'b1; end
                OP_SLTIU: alu_conf = ALU_COMP;
                default: ;
            endcase
        end
    end

    assign is_shift    = in_rex && (funct inside {F_SLL, F_SRL, F_SRA});
    // An unknown funct still executes as ADD; this flag later suppresses its writeback.
    assign funct_valid = funct inside {F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR,
                                       F_NOR, F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA};
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing the multi-cycle MIPS datapath.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    state_t      state_q, state_d;
    logic        pc_write, iord, mem_read, mem_write, ir_write, reg_write;
    logic        ext_op, lui_op, sign;
    reg_dst_t    reg_dst;
    mem_to_reg_t mem_to_reg;
    src_a_t      src_a;
    src_b_t      src_b;
    pc_src_t     pc_src;
    alu_conf_t   alu_conf, dec_conf;
    logic        dec_sign, dec_shift, dec_valid;

    multicycle_controller_alu_function_decode u_alu_function_decode (
        .op_code    (bus.OpCode),
        .funct      (bus.Funct),
        .in_rex     (state_q == S_REX),
        .alu_conf   (dec_conf),
        .sign       (dec_sign),
        .is_shift   (dec_shift),
        .funct_valid(dec_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = S_IF;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_RT;
        ext_op     = 1'b0;
        lui_op     = 1'b0;
        pc_src     = PC_ALU;
        alu_conf   = ALU_ADD;
        sign       = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = 1'b1;
                src_b    = SRCB_FOUR;
                pc_write = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                src_b  = SRCB_IMM_SL2;
                ext_op = 1'b1;
                case (bus.OpCode)
                    OP_LW, OP_SW: state_d = S_MADDR;
                    OP_RTYPE:     state_d = (bus.Funct == F_JR) ? S_JR : S_REX;
                    OP_BEQ:       state_d = S_BR;
                    OP_J, OP_JAL: state_d = S_JMP;
                    default:      state_d = is_imm_alu(bus.OpCode) ? S_IEX : S_IF;
                endcase
            end
            S_MADDR: begin
                src_a   = SRCA_RS;
                src_b   = SRCB_IMM;
                ext_op  = 1'b1;
                state_d = (bus.OpCode == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = S_LWWB;
            end
            S_LWWB: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_MDR;
            end
            S_MWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_REX: begin
                src_a    = dec_shift ? SRCA_SHAMT : SRCA_RS;
                alu_conf = dec_conf;
                sign     = dec_sign;
                state_d  = S_RWB;
            end
            S_RWB: begin
                reg_write = dec_valid;
                reg_dst   = DST_RD;
            end
            S_BR: begin
                src_a    = SRCA_RS;
                alu_conf = ALU_SUB;
                pc_src   = PC_ALUOUT;
                pc_write = bus.Zero;
            end
            S_JMP: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
                if (bus.OpCode == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = WB_PC;
                end
            end
            S_IEX: begin
                src_a    = SRCA_RS;
                src_b    = SRCB_IMM;
                ext_op   = bus.OpCode != OP_ANDI;
                lui_op   = bus.OpCode == OP_LUI;
                alu_conf = dec_conf;
                sign     = dec_sign;
                state_d  = S_IWB;
            end
            S_IWB: reg_write = 1'b1;
            S_JR: begin
                pc_src   = PC_RS;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are gated by reset so nothing commits while it is held.
    assign bus.PCWrite  = pc_write & reset;
    assign bus.MemWrite = mem_write & reset;
    assign bus.RegWrite = reg_write & reset;
    assign bus.IRWrite  = ir_write & reset;
    assign bus.IorD     = iord;
    assign bus.MemRead  = mem_read;
    assign bus.RegDst   = reg_dst;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.ALUSrcA  = src_a;
    assign bus.ALUSrcB  = src_b;
    assign bus.ExtOp    = ext_op;
    assign bus.LuiOp    = lui_op;
    assign bus.PCSource = pc_src;
    assign bus.ALUConf  = alu_conf;
    assign bus.Sign     = sign;
    assign bus.State    = STATE_W'(state_q);
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and randomized instruction sequences against a per-instruction reference model.
module tb_multicycle_controller;
    typedef struct packed {
        logic       pcw, iord, mr, mw, irw, rw;
        logic [1:0] rd, m2r, sa, sb;
        logic       ext, lui;
        logic [1:0] pcs;
        logic [4:0] conf;
        logic       sign;
    } outs_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    int    total = 0;
    int    bad = 0;
    int    act_st[8];
    outs_t act_o[8];

    multicycle_controller_if #(.STATE_W(4)) bus ();
    multicycle_controller #(.STATE_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic outs_t sample_outs();
        return {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp, bus.LuiOp,
                bus.PCSource, bus.ALUConf, bus.Sign};
    endfunction

    // Visited states for one instruction, derived from its class and cycle count.
    function automatic void ref_path(input logic [5:0] op, input logic [5:0] f,
                                     output int n, output int st[8]);
        st = '{default: 0};
        st[1] = 1;
        n = 2;
        case (op)
            6'h23: begin st[2] = 2; st[3] = 3; st[4] = 4; n = 5; end
            6'h2b: begin st[2] = 2; st[3] = 5; n = 4; end
            6'h00: if (f == 6'h08) begin st[2] = 12; n = 3; end
                   else begin st[2] = 6; st[3] = 7; n = 4; end
            6'h04: begin st[2] = 8; n = 3; end
            6'h02, 6'h03: begin st[2] = 9; n = 3; end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: begin st[2] = 10; st[3] = 11; n = 4; end
            default: ;
        endcase
    endfunction

    // {funct known, ALUConf, Sign} for R-type functions
    function automatic logic [6:0] ref_r(input logic [5:0] f);
        case (f)
            6'h20: return {1'b1, 5'd0, 1'b1};
            6'h21: return {1'b1, 5'd0, 1'b0};
            6'h22: return {1'b1, 5'd1, 1'b1};
            6'h23: return {1'b1, 5'd1, 1'b0};
            6'h24: return {1'b1, 5'd2, 1'b0};
            6'h25: return {1'b1, 5'd3, 1'b0};
            6'h26: return {1'b1, 5'd4, 1'b0};
            6'h27: return {1'b1, 5'd5, 1'b0};
            6'h2a: return {1'b1, 5'd8, 1'b1};
            6'h2b: return {1'b1, 5'd8, 1'b0};
            6'h00: return {1'b1, 5'd6, 1'b0};
            6'h02: return {1'b1, 5'd7, 1'b0};
            6'h03: return {1'b1, 5'd7, 1'b1};
            default: return {1'b0, 5'd0, 1'b0};
        endcase
    endfunction

    function automatic logic [5:0] ref_i(input logic [5:0] op);
        case (op)
            6'h08: return {5'd0, 1'b1};
            6'h0c: return {5'd2, 1'b0};
            6'h0a: return {5'd8, 1'b1};
            6'h0b: return {5'd8, 1'b0};
            default: return {5'd0, 1'b0};
        endcase
    endfunction

    function automatic outs_t ref_outs(input int st, input logic [5:0] op, input logic [5:0] f, input logic z);
        outs_t o = '0;
        logic [6:0] r = ref_r(f);
        case (st)
            0:  begin o.mr = 1; o.irw = 1; o.sb = 1; o.pcw = 1; end
            1:  begin o.sb = 3; o.ext = 1; end
            2:  begin o.sa = 1; o.sb = 2; o.ext = 1; end
            3:  begin o.mr = 1; o.iord = 1; end
            4:  begin o.rw = 1; o.m2r = 1; end
            5:  begin o.mw = 1; o.iord = 1; end
            6:  begin o.sa = (f == 6'h00 || f == 6'h02 || f == 6'h03) ? 2'd2 : 2'd1; o.conf = r[5:1]; o.sign = r[0]; end
            7:  begin o.rw = r[6]; o.rd = 1; end
            8:  begin o.sa = 1; o.conf = 5'd1; o.pcs = 1; o.pcw = z; end
            9:  begin o.pcs = 2; o.pcw = 1; if (op == 6'h03) begin o.rw = 1; o.rd = 2; o.m2r = 2; end end
            10: begin o.sa = 1; o.sb = 2; o.ext = (op != 6'h0c); o.lui = (op == 6'h0f); {o.conf, o.sign} = ref_i(op); end
            11: o.rw = 1;
            12: begin o.pcs = 3; o.pcw = 1; end
            default: ;
        endcase
        return o;
    endfunction

    // Starts shortly after a falling edge with the FSM in IF; ends on a falling edge.
    task automatic capture(input logic [5:0] op, input logic [5:0] f, input logic z, input int n);
        bus.OpCode = op;
        bus.Funct = f;
        bus.Zero = z;
        for (int i = 0; i < n; i++) begin
            #1;
            act_st[i] = int'(bus.State);
            act_o[i] = sample_outs();
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.OpCode = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL reset_state got %0d want 0", bus.State); end
        total++; if (bus.PCWrite !== 1'b0) begin bad++; $display("FAIL reset_pcwrite got %b want 0", bus.PCWrite); end
        total++; if (bus.IRWrite !== 1'b0) begin bad++; $display("FAIL reset_irwrite got %b want 0", bus.IRWrite); end
        total++; if (bus.MemRead !== 1'b1 || bus.ALUSrcB !== 2'd1) begin bad++; $display("FAIL reset_if_outs got mr=%b srcb=%0d want mr=1 srcb=1", bus.MemRead, bus.ALUSrcB); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (bus.PCWrite !== 1'b1 || bus.IRWrite !== 1'b1 || bus.State !== 4'd0) begin bad++; $display("FAIL release_if got pcw=%b irw=%b st=%0d want 1 1 0", bus.PCWrite, bus.IRWrite, bus.State); end
    endtask

    task automatic test_rtype_sub();
        int exp_s[4] = '{0, 1, 6, 7};
        capture(6'h00, 6'h22, 1'b0, 4);
        for (int i = 0; i < 4; i++) begin
            total++; if (act_st[i] !== exp_s[i]) begin bad++; $display("FAIL sub_state[%0d] got %0d want %0d", i, act_st[i], exp_s[i]); end
        end
        total++; if (act_o[2].conf !== 5'd1 || act_o[2].sign !== 1'b1) begin bad++; $display("FAIL sub_rex got conf=%0d sign=%b want 1 1", act_o[2].conf, act_o[2].sign); end
        total++; if (act_o[3].rw !== 1'b1 || act_o[3].rd !== 2'd1) begin bad++; $display("FAIL sub_rwb got rw=%b rd=%0d want 1 1", act_o[3].rw, act_o[3].rd); end
        #1;
        total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL sub_return got %0d want 0", bus.State); end
    endtask

    task automatic test_lw();
        int exp_s[5] = '{0, 1, 2, 3, 4};
        capture(6'h23, 6'h00, 1'b0, 5);
        for (int i = 0; i < 5; i++) begin
            total++; if (act_st[i] !== exp_s[i]) begin bad++; $display("FAIL lw_state[%0d] got %0d want %0d", i, act_st[i], exp_s[i]); end
        end
        total++; if (act_o[3].iord !== 1'b1 || act_o[3].mr !== 1'b1) begin bad++; $display("FAIL lw_mrd got iord=%b mr=%b want 1 1", act_o[3].iord, act_o[3].mr); end
        total++; if (act_o[4].m2r !== 2'd1 || act_o[4].rw !== 1'b1) begin bad++; $display("FAIL lw_wb got m2r=%0d rw=%b want 1 1", act_o[4].m2r, act_o[4].rw); end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            capture(6'h04, 6'h00, 1'(z), 3);
            total++; if (act_st[2] !== 8) begin bad++; $display("FAIL beq_state z=%0d got %0d want 8", z, act_st[2]); end
            total++; if (act_o[2].pcw !== 1'(z) || act_o[2].pcs !== 2'd1) begin bad++; $display("FAIL beq_br z=%0d got pcw=%b pcs=%0d want %0d 1", z, act_o[2].pcw, act_o[2].pcs, z); end
            #1;
            total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL beq_return z=%0d got %0d want 0", z, bus.State); end
        end
    endtask

    task automatic test_jal();
        capture(6'h03, 6'h00, 1'b0, 3);
        total++; if (act_st[2] !== 9) begin bad++; $display("FAIL jal_state got %0d want 9", act_st[2]); end
        total++; if (act_o[2].pcw !== 1'b1 || act_o[2].pcs !== 2'd2 || act_o[2].rw !== 1'b1 || act_o[2].rd !== 2'd2 || act_o[2].m2r !== 2'd2)
            begin bad++; $display("FAIL jal_jmp got pcw=%b pcs=%0d rw=%b rd=%0d m2r=%0d want 1 2 1 2 2", act_o[2].pcw, act_o[2].pcs, act_o[2].rw, act_o[2].rd, act_o[2].m2r); end
    endtask

    task automatic test_illegal();
        capture(6'h3f, 6'h00, 1'b0, 2);
        total++; if (act_st[1] !== 1) begin bad++; $display("FAIL ill_state got %0d want 1", act_st[1]); end
        total++; if ({act_o[1].pcw, act_o[1].mw, act_o[1].rw, act_o[1].irw} !== 4'b0) begin bad++; $display("FAIL ill_strobes got %b want 0000", {act_o[1].pcw, act_o[1].mw, act_o[1].rw, act_o[1].irw}); end
        #1;
        total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL ill_return got %0d want 0", bus.State); end
    endtask

    task automatic test_reset_in_mwr();
        capture(6'h2b, 6'h00, 1'b0, 3);
        #1;
        total++; if (bus.State !== 4'd5 || bus.MemWrite !== 1'b1) begin bad++; $display("FAIL sw_mwr got st=%0d mw=%b want 5 1", bus.State, bus.MemWrite); end
        reset = 1'b0;
        #1;
        total++; if (bus.MemWrite !== 1'b0 || bus.State !== 4'd0) begin bad++; $display("FAIL mwr_reset got mw=%b st=%0d want 0 0", bus.MemWrite, bus.State); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (bus.IRWrite !== 1'b1 || bus.MemWrite !== 1'b0 || bus.State !== 4'd0) begin bad++; $display("FAIL mwr_restart got irw=%b mw=%b st=%0d want 1 0 0", bus.IRWrite, bus.MemWrite, bus.State); end
    endtask

    task automatic test_random();
        logic [5:0] ops[14] = '{6'h23, 6'h2b, 6'h00, 6'h00, 6'h04, 6'h02, 6'h03, 6'h08, 6'h09, 6'h0c, 6'h0a, 6'h0b, 6'h0f, 6'h00};
        logic [5:0] fns[15] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00};
        for (int k = 0; k < 120; k++) begin
            logic [5:0] op, f;
            logic z;
            int n;
            int st[8];
            int si = int'($urandom_range(0, 13));
            int fi = int'($urandom_range(0, 14));
            op = (si == 13) ? 6'($urandom_range(0, 63)) : ops[si];
            f = (fi == 14) ? 6'($urandom_range(0, 63)) : fns[fi];
            z = 1'($urandom_range(0, 1));
            ref_path(op, f, n, st);
            capture(op, f, z, n);
            for (int i = 0; i < n; i++) begin
                outs_t e = ref_outs(st[i], op, f, z);
                total++; if (act_st[i] !== st[i]) begin bad++; $display("FAIL rnd%0d op=%h f=%h cyc%0d state got %0d want %0d", k, op, f, i, act_st[i], st[i]); end
                total++; if (act_o[i] !== e) begin bad++; $display("FAIL rnd%0d op=%h f=%h z=%b cyc%0d outs got %h want %h", k, op, f, z, i, act_o[i], e); end
            end
            #1;
            total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL rnd%0d op=%h end_state got %0d want 0", k, op, bus.State); end
        end
    endtask

    initial begin
        test_reset();
        test_rtype_sub();
        test_lw();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_in_mwr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
